bgr_startup_ctrl: RTL

BGR_STARTUP_CTRL -- requirements
Module: bgr_startup_ctrl

---
 rtl/bgr_startup_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bgr_startup_ctrl.sv
// ---------------------------------------------------------------------------
// bgr_startup_ctrl
//
// Start-up sequencer for a bandgap reference. It pulses the bandgap porst
// pin, waits for the core to settle, then qualifies the comparator flag
// vbg_ok for a run of consecutive good cycles before declaring the
// reference ready. While ready it watches for a sustained loss of vbg_ok
// and re-kicks the bandgap. Qualification attempts that time out are
// retried a bounded number of times before the block parks in FAULT.
//
// Ports
//   clk        block clock, all flops on the rising edge
//   rst_n      asynchronous active-low reset
//   en         synchronous enable, 1 requests start-up, 0 forces IDLE
//   vbg_ok     asynchronous comparator flag, synchronized internally
//   porst      registered bandgap start-up kick, active high
//   ready      registered, reference qualified and stable
//   fault      registered, sticky until en=0, retries exhausted
//   retry_cnt  registered count of re-kicks in the current start sequence
// ---------------------------------------------------------------------------
module bgr_startup_ctrl #(
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int STABLE_CYCLES = 32,
  parameter int QUAL_TIMEOUT  = 128,
  parameter int DROP_CYCLES   = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       vbg_ok,
  output logic       porst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    SETTLE,
    QUALIFY,
    READY,
    FAULT
  } state_t;

  // Terminal values of the counters, sized to the counters they are
  // compared against. A phase of N cycles ends when its counter reads N-1.
  localparam logic [8:0] KICK_LAST   = 9'(KICK_CYCLES - 1);
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_CYCLES - 1);
  localparam logic [8:0] QUAL_LAST   = 9'(QUAL_TIMEOUT - 1);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] DROP_LAST   = 8'(DROP_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_t     state;
  logic [8:0] cyc_cnt;
  logic [7:0] run_cnt;
  logic       vbg_meta;
  logic       vbg_ok_s;

  // Two-flop synchronizer for the comparator flag. The comparator output
  // is asynchronous to clk, so nothing downstream may look at vbg_ok
  // directly; every decision uses vbg_ok_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbg_meta <= 1'b0;
      vbg_ok_s <= 1'b0;
    end else begin
      vbg_meta <= vbg_ok;
      vbg_ok_s <= vbg_meta;
    end
  end

  // Sequencer. cyc_cnt is the shared phase timer (kick width, settle time,
  // qualify window). run_cnt counts consecutive good samples in QUALIFY
  // and consecutive bad samples in READY. Outputs are updated together
  // with the state so they always match the state being entered, which
  // keeps porst and ready mutually exclusive flop outputs. Dropping en
  // overrides everything. In QUALIFY the stable check comes before the
  // timeout check so a run that completes on the last window cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      porst     <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 3'd0;
      cyc_cnt   <= 9'd0;
      run_cnt   <= 8'd0;
    end else if (!en) begin
      state     <= IDLE;
      porst     <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 3'd0;
      cyc_cnt   <= 9'd0;
      run_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state   <= KICK;
          porst   <= 1'b1;
          cyc_cnt <= 9'd0;
          run_cnt <= 8'd0;
        end
        KICK: begin
          if (cyc_cnt == KICK_LAST) begin
            state   <= SETTLE;
            porst   <= 1'b0;
            cyc_cnt <= 9'd0;
          end else begin
            cyc_cnt <= cyc_cnt + 9'd1;
          end
        end
        SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            state   <= QUALIFY;
            cyc_cnt <= 9'd0;
            run_cnt <= 8'd0;
          end else begin
            cyc_cnt <= cyc_cnt + 9'd1;
          end
        end
        QUALIFY: begin
          if (vbg_ok_s && (run_cnt == STABLE_LAST)) begin
            state   <= READY;
            ready   <= 1'b1;
            cyc_cnt <= 9'd0;
            run_cnt <= 8'd0;
          end else if (cyc_cnt == QUAL_LAST) begin
            cyc_cnt <= 9'd0;
            run_cnt <= 8'd0;
            if (retry_cnt < RETRY_MAX) begin
              state     <= KICK;
              porst     <= 1'b1;
              retry_cnt <= retry_cnt + 3'd1;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 9'd1;
            run_cnt <= vbg_ok_s ? (run_cnt + 8'd1) : 8'd0;
          end
        end
        READY: begin
          if (!vbg_ok_s) begin
            if (run_cnt == DROP_LAST) begin
              state     <= KICK;
              ready     <= 1'b0;
              porst     <= 1'b1;
              retry_cnt <= 3'd0;
              cyc_cnt   <= 9'd0;
              run_cnt   <= 8'd0;
            end else begin
              run_cnt <= run_cnt + 8'd1;
            end
          end else begin
            run_cnt <= 8'd0;
          end
        end
        FAULT: begin
          porst <= 1'b0;
          ready <= 1'b0;
          fault <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          porst     <= 1'b0;
          ready     <= 1'b0;
          fault     <= 1'b0;
          retry_cnt <= 3'd0;
          cyc_cnt   <= 9'd0;
          run_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule
